// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, reset PC, bubble
// instruction, control-transfer opcodes and the fetch FSM state encoding.
package riscv_pkg;

    localparam int unsigned RV_XLEN      = 32;
    localparam logic [31:0] RV_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic is_ctrl_xfer(input logic [31:0] instr);
        return (instr[6:0] == OPC_BRANCH) || (instr[6:0] == OPC_JAL) ||
               (instr[6:0] == OPC_JALR);
    endfunction

endpackage

// File: rtl/riscv_ifid_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise contents hold.
// A bubble clears valid and the instruction but keeps the last PC pair.
module riscv_ifid_reg
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = RV_XLEN,
    parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            bubble,
    input  logic [31:0]     ld_instr,
    input  logic [XLEN-1:0] ld_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    logic            valid_r;
    logic [31:0]     instr_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_plus4_r;

    // IF/ID storage with bubble > load > hold priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            instr_r    <= NOP_INSTR;
            pc_r       <= '0;
            pc_plus4_r <= '0;
        end else if (bubble) begin
            valid_r    <= 1'b0;
            instr_r    <= NOP_INSTR;
        end else if (load) begin
            valid_r    <= 1'b1;
            instr_r    <= ld_instr;
            pc_r       <= ld_pc;
            pc_plus4_r <= ld_pc + PC_STEP;
        end else begin
            valid_r    <= valid_r;
            instr_r    <= instr_r;
        end
    end

    assign valid    = valid_r;
    assign instr    = instr_r;
    assign pc       = pc_r;
    assign pc_plus4 = pc_plus4_r;

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch stage: PC, instruction-memory handshake, skid buffer for
// stalled responses, redirect/drain handling, and the IF/ID register.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = RV_XLEN,
    parameter logic [31:0] RESET_PC  = RV_RESET_PC,
    parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pcSrc,
    input  logic            flush,
    input  logic [XLEN-1:0] targetAddr,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            ifid_valid,
    output logic [31:0]     ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pcPlus4
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);
    localparam logic [XLEN-1:0] PC_INIT = XLEN'(RESET_PC);

    fetch_state_e    state_r, state_n;
    logic [XLEN-1:0] pc_r, pc_n;
    logic [XLEN-1:0] addr_r, addr_n;
    logic            req_r, req_n;
    logic            skid_valid_r, skid_valid_n;
    logic [31:0]     skid_instr_r, skid_instr_n;
    logic [XLEN-1:0] skid_pc_r, skid_pc_n;

    logic [XLEN-1:0] target_s;
    logic            accept_s;
    logic [31:0]     acc_instr_s;
    logic [XLEN-1:0] acc_pc_s;
    logic            ifid_load_s;
    logic            ifid_bubble_s;
    logic            unused_tgt_lsb_s;

    assign target_s         = {targetAddr[XLEN-1:2], 2'b00};
    assign unused_tgt_lsb_s = ^targetAddr[1:0];

    // Fetch FSM next state, PC, skid buffer and accepted-instruction select
    always_comb begin
        state_n      = state_r;
        pc_n         = pc_r;
        skid_valid_n = skid_valid_r;
        skid_instr_n = skid_instr_r;
        skid_pc_n    = skid_pc_r;
        accept_s     = 1'b0;
        acc_instr_s  = imem_rdata;
        acc_pc_s     = pc_r;
        case (state_r)
            ST_IDLE: begin
                if (pcSrc) begin
                    pc_n         = target_s;
                    skid_valid_n = 1'b0;
                end else begin
                    pc_n = pc_r;
                end
                state_n = ST_FETCH;
            end
            ST_FETCH: begin
                if (pcSrc) begin
                    pc_n         = target_s;
                    skid_valid_n = 1'b0;
                    state_n      = imem_ready ? ST_FETCH : ST_DRAIN;
                end else if (imem_ready && stall) begin
                    skid_valid_n = 1'b1;
                    skid_instr_n = imem_rdata;
                    skid_pc_n    = pc_r;
                    state_n      = ST_HOLD;
                end else if (imem_ready) begin
                    accept_s = 1'b1;
                    pc_n     = pc_r + PC_STEP;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (pcSrc) begin
                    pc_n         = target_s;
                    skid_valid_n = 1'b0;
                    state_n      = ST_FETCH;
                end else if (!stall) begin
                    accept_s     = skid_valid_r;
                    acc_instr_s  = skid_instr_r;
                    acc_pc_s     = skid_pc_r;
                    pc_n         = pc_r + PC_STEP;
                    skid_valid_n = 1'b0;
                    state_n      = ST_FETCH;
                end else begin
                    state_n = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (pcSrc) begin
                    pc_n         = target_s;
                    skid_valid_n = 1'b0;
                end else begin
                    pc_n = pc_r;
                end
                // The outstanding response is consumed here and thrown away
                if (imem_ready) begin
                    state_n = ST_FETCH;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: begin
                state_n      = ST_IDLE;
                skid_valid_n = 1'b0;
            end
        endcase
    end

    // Request outputs: a drain keeps presenting the address already in flight
    always_comb begin
        req_n  = (state_n == ST_FETCH) || (state_n == ST_DRAIN);
        addr_n = addr_r;
        if (state_n == ST_FETCH) begin
            addr_n = pc_n;
        end else begin
            addr_n = addr_r;
        end
    end

    // IF/ID control: flush wins, stall holds, otherwise load or bubble
    always_comb begin
        ifid_load_s   = accept_s && !flush;
        ifid_bubble_s = flush || (!stall && !accept_s);
    end

    // Fetch state, PC, request and skid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= PC_INIT;
            addr_r       <= PC_INIT;
            req_r        <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_instr_r <= NOP_INSTR;
            skid_pc_r    <= '0;
        end else begin
            state_r      <= state_n;
            pc_r         <= pc_n;
            addr_r       <= addr_n;
            req_r        <= req_n;
            skid_valid_r <= skid_valid_n;
            skid_instr_r <= skid_instr_n;
            skid_pc_r    <= skid_pc_n;
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = addr_r;

    riscv_ifid_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ifid_load_s),
        .bubble   (ifid_bubble_s),
        .ld_instr (acc_instr_s),
        .ld_pc    (acc_pc_s),
        .valid    (ifid_valid),
        .instr    (ifid_instr),
        .pc       (ifid_pc),
        .pc_plus4 (ifid_pcPlus4)
    );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: sequential fetch, wait states, stall/skid,
// redirect with drain, redirect during hold, PC wrap and mid-request reset.
module tb_riscv_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        pcSrc;
    logic        flush;
    logic [31:0] targetAddr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pcPlus4;

    int n_vec_s;
    int n_err_s;

    riscv_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pcSrc        (pcSrc),
        .flush        (flush),
        .targetAddr   (targetAddr),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pcPlus4 (ifid_pcPlus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check_vec(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec_s++;
        if (obs !== exp) begin
            n_err_s++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc);
        check_vec({tag, ".valid"}, {31'd0, ifid_valid}, 32'd1);
        check_vec({tag, ".pc"}, ifid_pc, pc);
        check_vec({tag, ".instr"}, ifid_instr, mem_word(pc));
        check_vec({tag, ".pc4"}, ifid_pcPlus4, pc + 32'd4);
    endtask

    initial begin
        n_vec_s    = 0;
        n_err_s    = 0;
        rst_n      = 1'b0;
        pcSrc      = 1'b0;
        flush      = 1'b0;
        targetAddr = 32'd0;
        stall      = 1'b0;
        imem_ready = 1'b1;

        // reset values
        tick();
        tick();
        check_vec("rst.req", {31'd0, imem_req}, 32'd0);
        check_vec("rst.valid", {31'd0, ifid_valid}, 32'd0);
        check_vec("rst.instr", ifid_instr, NOP);
        check_vec("rst.pc", ifid_pc, 32'd0);
        check_vec("rst.pc4", ifid_pcPlus4, 32'd0);
        rst_n = 1'b1;
        tick();
        check_vec("idle.req", {31'd0, imem_req}, 32'd1);
        check_vec("idle.valid", {31'd0, ifid_valid}, 32'd0);

        // 1: back-to-back fetch, IF/ID trails the address by one cycle
        for (int i = 0; i < 4; i++) begin
            check_vec("seq.addr", imem_addr, 32'(4 * i));
            tick();
            check_ifid("seq", 32'(4 * i));
        end

        // 2: three wait states at 0x10
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("wait.addr", imem_addr, 32'h10);
            check_vec("wait.req", {31'd0, imem_req}, 32'd1);
            check_vec("wait.valid", {31'd0, ifid_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        tick();
        check_ifid("wait.done", 32'h10);
        tick();
        tick();
        tick();
        check_vec("pre_stall.addr", imem_addr, 32'h20);

        // 3: stall while the response for 0x20 arrives
        stall = 1'b1;
        tick();
        check_vec("hold.req", {31'd0, imem_req}, 32'd0);
        check_ifid("hold.keep", 32'h1C);
        tick();
        check_vec("hold2.req", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        check_ifid("unstall", 32'h20);
        check_vec("unstall.addr", imem_addr, 32'h24);
        check_vec("unstall.req", {31'd0, imem_req}, 32'd1);
        tick();
        check_ifid("after_skid", 32'h24);
        check_vec("after_skid.addr", imem_addr, 32'h28);

        // 4: redirect + flush while the request at 0x28 is outstanding
        imem_ready = 1'b0;
        pcSrc      = 1'b1;
        flush      = 1'b1;
        targetAddr = 32'h103;
        tick();
        pcSrc = 1'b0;
        flush = 1'b0;
        check_vec("drain.addr", imem_addr, 32'h28);
        check_vec("drain.req", {31'd0, imem_req}, 32'd1);
        check_vec("drain.valid", {31'd0, ifid_valid}, 32'd0);
        tick();
        check_vec("drain2.addr", imem_addr, 32'h28);
        check_vec("drain2.valid", {31'd0, ifid_valid}, 32'd0);
        imem_ready = 1'b1;
        tick();
        check_vec("redir.addr", imem_addr, 32'h100);
        check_vec("redir.valid", {31'd0, ifid_valid}, 32'd0);
        tick();
        check_ifid("redir.first", 32'h100);

        // 5: redirect and stall together while holding a skid entry
        stall = 1'b1;
        tick();
        check_vec("hold5.req", {31'd0, imem_req}, 32'd0);
        pcSrc      = 1'b1;
        targetAddr = 32'h200;
        tick();
        check_vec("hold5.addr", imem_addr, 32'h200);
        check_vec("hold5.req2", {31'd0, imem_req}, 32'd1);
        pcSrc = 1'b0;
        stall = 1'b0;
        tick();
        check_ifid("hold5.new", 32'h200);

        // 6: PC wraps past the top of the address space
        pcSrc      = 1'b1;
        targetAddr = 32'hFFFF_FFFE;
        tick();
        pcSrc = 1'b0;
        check_vec("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        check_vec("wrap.drop", {31'd0, ifid_valid}, 32'd0);
        tick();
        check_vec("wrap.addr", imem_addr, 32'h0);
        check_vec("wrap.pc", ifid_pc, 32'hFFFF_FFFC);
        check_vec("wrap.pc4", ifid_pcPlus4, 32'h0);

        // flush alone empties IF/ID
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_vec("flush.valid", {31'd0, ifid_valid}, 32'd0);
        check_vec("flush.instr", ifid_instr, NOP);

        // reset pulse while a request is outstanding
        imem_ready = 1'b0;
        tick();
        check_vec("mid.req", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("arst.req", {31'd0, imem_req}, 32'd0);
        check_vec("arst.valid", {31'd0, ifid_valid}, 32'd0);
        check_vec("arst.instr", ifid_instr, NOP);
        tick();
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        tick();
        check_vec("restart.addr", imem_addr, 32'h0);
        check_vec("restart.req", {31'd0, imem_req}, 32'd1);
        tick();
        check_ifid("restart", 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec_s, n_err_s);
        $finish;
    end

endmodule
